// File: rtl/modpow_feeder.sv
// rtl/modpow_feeder.sv - request FIFO and settle/hold sequencer feeding a combinational modexp core
// Optional feature macro: MODPOW_FEEDER_ERRCHK_EN (flag and zero results whose modulus is 0).
module modpow_feeder #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_n,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic [WIDTH-1:0] core_n,
  input  logic [WIDTH-1:0] core_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_HOLD} state_t;

  state_t             state;
  logic [3*WIDTH-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [3:0]         cnt;
  logic [3*WIDTH-1:0] head;
  logic               full;
  logic               empty;
  logic               wr_en;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign wr_en    = in_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign busy     = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {in_a, in_b, in_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
  end

`ifdef MODPOW_FEEDER_ERRCHK_EN
  logic err_pend;
`else
  assign out_err = 1'b0;
`endif

  // The only FIFO reader is LOAD, which is entered only while the FIFO is non-empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      cnt       <= '0;
      core_a    <= '0;
      core_b    <= '0;
      core_n    <= '0;
      out_res   <= '0;
      out_valid <= 1'b0;
`ifdef MODPOW_FEEDER_ERRCHK_EN
      err_pend  <= 1'b0;
      out_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) state <= S_LOAD;
        end
        S_LOAD: begin
          {core_a, core_b, core_n} <= head;
          rd_ptr <= rd_ptr + 1'b1;
          cnt    <= 4'(SETTLE - 1);
          state  <= S_SETTLE;
`ifdef MODPOW_FEEDER_ERRCHK_EN
          err_pend <= (head[WIDTH-1:0] == '0);
`endif
        end
        S_SETTLE: begin
          if (cnt == 4'd0) begin
`ifdef MODPOW_FEEDER_ERRCHK_EN
            out_res <= err_pend ? '0 : core_res;
            out_err <= err_pend;
`else
            out_res <= core_res;
`endif
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef MODPOW_FEEDER_ERRCHK_EN
            out_err   <= 1'b0;
`endif
            state     <= empty ? S_IDLE : S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
